neopixel_driver: RTL and testbench

Consumer end of the NeoPixel load/send handshake. The producer FSM writes per-pixel colour bytes into an internal register file through load_color. The producer then issues send_it. The block serialises the whole strip as WS2812 GRB frames on neo_data, holds the line low for the latch/reset interval, and signals completion.

---
 rtl/neopixel_driver.sv | 216 +++++++++++++++++++++
 tb/tb_neopixel_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_driver.sv
// WS2812 strip driver: per-pixel GRB register file loaded by a producer,
// serialised on neo_data as one frame per send_it, followed by a latch interval.
module neopixel_driver #(
    parameter int unsigned NUM_PIXELS   = 5,
    parameter int unsigned T0H          = 17,
    parameter int unsigned T0L          = 40,
    parameter int unsigned T1H          = 35,
    parameter int unsigned T1L          = 30,
    parameter int unsigned RESET_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_color,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       begin_send,
    output logic       done_send,
    output logic       done_wait
);

    localparam int unsigned MAX_H    = (T0H > T1H) ? T0H : T1H;
    localparam int unsigned MAX_L    = (T0L > T1L) ? T0L : T1L;
    localparam int unsigned MAX_HL   = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int unsigned MAX_T    = (MAX_HL > RESET_CYCLES) ? MAX_HL : RESET_CYCLES;
    localparam int unsigned TMR_W    = $clog2(MAX_T + 1);
    localparam int unsigned NUM_BITS = NUM_PIXELS * 24;
    localparam int unsigned BIT_W    = $clog2(NUM_BITS);
    localparam int unsigned PIX_W    = 3;
    localparam int unsigned POS_W    = 5;
    localparam int unsigned WORD_W   = 24;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_BITS - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [TMR_W-1:0]                timer_q, timer_d;
    logic [BIT_W-1:0]                bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]                pix_q, pix_d;
    logic [POS_W-1:0]                pos_q, pos_d;
    logic [WORD_W-1:0]               shift_q, shift_d;
    logic [NUM_PIXELS-1:0][2:0][7:0] mem_q;

    logic neo_data_q, neo_data_d;
    logic ready_q, ready_d;
    logic begin_send_q, begin_send_d;
    logic done_send_q, done_send_d;
    logic done_wait_q, done_wait_d;

    logic              wr_en;
    logic [WORD_W-1:0] first_word;
    logic [WORD_W-1:0] next_word;
    logic [PIX_W-1:0]  pix_nxt;

    // Write qualifier: only in IDLE, only for existing pixels and real colours
    always_comb begin
        wr_en = load_color && (state_q == IDLE)
                && (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
    end

    // Colour register file; cleared by reset, otherwise persistent
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (wr_en) begin
            for (int p = 0; p < int'(NUM_PIXELS); p++) begin
                for (int c = 0; c < 3; c++) begin
                    if (pixel_index == PIX_W'(p) && color_index == 2'(c)) begin
                        mem_q[p][c] <= color_level;
                    end
                end
            end
        end
    end

    // Pixel 0 word for frame start, forwarding a same-cycle write into it
    always_comb begin
        first_word = {mem_q[0][0], mem_q[0][1], mem_q[0][2]};
        if (wr_en && pixel_index == '0) begin
            case (color_index)
                2'd0:    first_word[23:16] = color_level;
                2'd1:    first_word[15:8]  = color_level;
                2'd2:    first_word[7:0]   = color_level;
                default: first_word        = first_word;
            endcase
        end
    end

    // Word of the pixel following the current one (GRB, green in the MSBs)
    always_comb begin
        pix_nxt   = pix_q + PIX_W'(1);
        next_word = '0;
        for (int p = 0; p < int'(NUM_PIXELS); p++) begin
            if (PIX_W'(p) == pix_nxt) begin
                next_word = {mem_q[p][0], mem_q[p][1], mem_q[p][2]};
            end
        end
    end

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        pix_d     = pix_q;
        pos_d     = pos_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (send_it) begin
                    state_d   = HIGH;
                    bit_cnt_d = '0;
                    pix_d     = '0;
                    pos_d     = '0;
                    shift_d   = first_word;
                    timer_d   = first_word[WORD_W-1] ? TMR_W'(T1H - 1) : TMR_W'(T0H - 1);
                end
            end
            HIGH: begin
                if (timer_q == '0) begin
                    state_d = LOW;
                    timer_d = shift_q[WORD_W-1] ? TMR_W'(T1L - 1) : TMR_W'(T0L - 1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LOW: begin
                if (timer_q == '0) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = LATCH;
                        timer_d = TMR_W'(RESET_CYCLES - 1);
                    end else begin
                        state_d   = HIGH;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (pos_q == LAST_POS) begin
                            pix_d   = pix_nxt;
                            pos_d   = '0;
                            shift_d = next_word;
                        end else begin
                            pos_d   = pos_q + POS_W'(1);
                            shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        end
                        timer_d = shift_d[WORD_W-1] ? TMR_W'(T1H - 1) : TMR_W'(T0H - 1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LATCH: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        neo_data_d   = (state_d == HIGH);
        ready_d      = (state_d == IDLE);
        begin_send_d = (state_q == IDLE) && send_it;
        done_send_d  = (state_d == LOW) && (timer_d == '0) && (bit_cnt_d == LAST_BIT);
        done_wait_d  = (state_d == LATCH) && (timer_d == '0);
    end

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            pix_q        <= '0;
            pos_q        <= '0;
            shift_q      <= '0;
            neo_data_q   <= 1'b0;
            ready_q      <= 1'b1;
            begin_send_q <= 1'b0;
            done_send_q  <= 1'b0;
            done_wait_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_q        <= pix_d;
            pos_q        <= pos_d;
            shift_q      <= shift_d;
            neo_data_q   <= neo_data_d;
            ready_q      <= ready_d;
            begin_send_q <= begin_send_d;
            done_send_q  <= done_send_d;
            done_wait_q  <= done_wait_d;
        end
    end

    assign neo_data      = neo_data_q;
    assign ready_to_load = ready_q;
    assign ready_to_send = ready_q;
    assign begin_send    = begin_send_q;
    assign done_send     = done_send_q;
    assign done_wait     = done_wait_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Bench for neopixel_driver: frame-level reference model plus literal spot checks.
module tb_neopixel_driver;

    localparam int NPIX  = 5;
    localparam int NBITS = NPIX * 24;
    localparam logic [4:0] IDLE_V = 5'b00001; // {neo, begin, done_send, done_wait, ready}

    logic       clock;
    logic       reset;
    logic       load_color;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait;

    int total = 0;
    int bad   = 0;

    neopixel_driver dut (
        .clock        (clock),
        .reset        (reset),
        .load_color   (load_color),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .send_it      (send_it),
        .neo_data     (neo_data),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send),
        .begin_send   (begin_send),
        .done_send    (done_send),
        .done_wait    (done_wait)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state
    logic [7:0] mem_m [0:NPIX-1][0:2];
    logic [4:0] q [$];
    logic [4:0] cur = IDLE_V;

    // Waveform measurements
    int widths [0:NBITS-1];
    int bit_idx  = 0;
    int run      = 0;
    int fcyc     = 0;
    int ds_at    = 0;
    int dw_at    = 0;
    int dw_count = 0;
    int ds_count = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of one whole frame from the colour bytes
    task automatic build_frame();
        int  n, hi, lo;
        logic v;
        for (int p = 0; p < NPIX; p++) begin
            for (int c = 0; c < 3; c++) begin
                for (int b = 7; b >= 0; b--) begin
                    v  = mem_m[p][c][b];
                    n  = p * 24 + c * 8 + (7 - b);
                    hi = v ? 35 : 17;
                    lo = v ? 30 : 40;
                    for (int k = 0; k < hi; k++)
                        q.push_back({1'b1, (n == 0 && k == 0), 1'b0, 1'b0, 1'b0});
                    for (int k = 0; k < lo; k++)
                        q.push_back({1'b0, 1'b0, (n == NBITS - 1 && k == lo - 1), 1'b0, 1'b0});
                end
            end
        end
        for (int k = 0; k < 2500; k++)
            q.push_back({1'b0, 1'b0, 1'b0, (k == 2499), 1'b0});
    endtask

    // Model: accepts writes/sends only while idle, then plays the frame back
    initial begin
        for (int p = 0; p < NPIX; p++) for (int c = 0; c < 3; c++) mem_m[p][c] = 8'h00;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                q.delete();
                cur = IDLE_V;
                for (int p = 0; p < NPIX; p++) for (int c = 0; c < 3; c++) mem_m[p][c] = 8'h00;
            end else begin
                if (cur[0]) begin
                    if (load_color && int'(pixel_index) < NPIX && color_index != 2'd3)
                        mem_m[int'(pixel_index)][int'(color_index)] = color_level;
                    if (send_it) build_frame();
                end
                if (q.size() > 0) cur = q.pop_front();
                else cur = IDLE_V;
            end
        end
    end

    // Cycle-by-cycle compare against the model
    initial begin
        logic [5:0] got6, exp6;
        forever begin
            @(negedge clock);
            got6 = {neo_data, begin_send, done_send, done_wait, ready_to_load, ready_to_send};
            exp6 = {cur, cur[0]};
            total++;
            if (got6 !== exp6) begin
                bad++;
                $display("FAIL outputs {neo,begin,dsend,dwait,rl,rs}: got %b expected %b at %0t",
                         got6, exp6, $time);
            end
        end
    end

    // Measures high widths per bit and pulse positions within a frame
    initial begin
        forever begin
            @(negedge clock);
            if (begin_send) begin
                fcyc = 0; bit_idx = 0; run = 0;
            end
            fcyc++;
            if (neo_data) run++;
            else if (run != 0) begin
                if (bit_idx < NBITS) widths[bit_idx] = run;
                bit_idx++;
                run = 0;
            end
            if (done_send) begin ds_at = fcyc; ds_count++; end
            if (done_wait) begin dw_at = fcyc; dw_count++; end
        end
    end

    function automatic int count_ones();
        int n = 0;
        for (int i = 0; i < NBITS; i++) if (widths[i] == 35) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load_color = 1'b0; send_it = 1'b0;
        pixel_index = '0; color_index = '0; color_level = '0;
    endtask

    task automatic wr(input int p, input int c, input int v);
        load_color = 1'b1; pixel_index = 3'(p); color_index = 2'(c); color_level = 8'(v);
        tick();
        idle_inputs();
    endtask

    // Starts a frame (any write fields already set go in the same cycle),
    // optionally jamming random inputs while busy, optionally aborting by reset
    task automatic send_frame(input bit noise, input int abort_bit);
        int dw0, ds0;
        bit finished;
        dw0 = dw_count;
        ds0 = ds_count;
        finished = 1'b0;
        send_it = 1'b1;
        tick();
        idle_inputs();
        chk("begin_send_latency", int'(begin_send), 1);
        chk("neo_high_first_cycle", int'(neo_data), 1);
        for (int i = 0; i < 12000; i++) begin
            tick();
            if (abort_bit >= 0 && i > 2 && bit_idx >= abort_bit) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_neo_low", int'(neo_data), 0);
                chk("abort_ready", int'(ready_to_send), 1);
                idle_inputs();
                repeat (3) tick();
                reset = 1'b0;
                repeat (20) tick();
                chk("abort_no_done_send", ds_count - ds0, 0);
                chk("abort_no_done_wait", dw_count - dw0, 0);
                finished = 1'b1;
                break;
            end
            if (dw_count != dw0) begin
                idle_inputs();
                finished = 1'b1;
                break;
            end
            if (noise) begin
                load_color  = 1'($urandom_range(0, 1));
                send_it     = 1'($urandom_range(0, 1));
                pixel_index = 3'($urandom_range(0, 7));
                color_index = 2'($urandom_range(0, 3));
                color_level = 8'($urandom);
            end
        end
        idle_inputs();
        if (!finished) chk("frame_timeout", 0, 1);
        else if (abort_bit < 0) chk("ready_after_frame", int'(ready_to_send & ready_to_load), 1);
    endtask

    initial begin
        int exp_a5 [0:7];
        int ok;
        exp_a5 = '{35, 17, 35, 17, 17, 35, 17, 35};
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        chk("reset_neo", int'(neo_data), 0);
        chk("reset_ready_load", int'(ready_to_load), 1);
        reset = 1'b0;
        tick();
        chk("idle_ready_send", int'(ready_to_send), 1);
        chk("idle_begin", int'(begin_send), 0);

        // All-zero frame after reset
        send_frame(1'b0, -1);
        chk("zero_frame_ones", count_ones(), 0);
        chk("zero_frame_done_send_cycle", ds_at, 6840);
        chk("zero_frame_done_wait_cycle", dw_at, 9340);

        // Pixel0 G=A5, pixel4 B=01, plus writes that must be dropped
        wr(0, 0, 8'hA5);
        wr(4, 2, 8'h01);
        wr(1, 3, 8'hFF);
        wr(5, 0, 8'hFF);
        send_frame(1'b1, -1);
        ok = 1;
        for (int i = 0; i < 8; i++) if (widths[i] != exp_a5[i]) ok = 0;
        chk("a5_first_byte_widths", ok, 1);
        chk("last_bit_is_one", widths[NBITS - 1], 35);
        chk("a5_frame_ones", count_ones(), 5);

        // Repeat with jammed inputs: identical frame, no register change
        send_frame(1'b1, -1);
        ok = 1;
        for (int i = 0; i < 8; i++) if (widths[i] != exp_a5[i]) ok = 0;
        chk("repeat_first_byte_widths", ok, 1);
        chk("repeat_frame_ones", count_ones(), 5);

        // Write and send in the same cycle: pixel0 R=FF appears immediately
        load_color = 1'b1; pixel_index = 3'd0; color_index = 2'd1; color_level = 8'hFF;
        send_frame(1'b0, -1);
        ok = 1;
        for (int i = 8; i < 16; i++) if (widths[i] != 35) ok = 0;
        chk("same_cycle_red_bits", ok, 1);
        chk("same_cycle_frame_ones", count_ones(), 13);

        // Random contents
        repeat (12) wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255));
        send_frame(1'b1, -1);
        repeat (8) wr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(1, 255));

        // Reset around bit 50, then the register file must read back as zeros
        send_frame(1'b1, 50);
        send_frame(1'b0, -1);
        chk("post_abort_ones", count_ones(), 0);
        chk("post_abort_done_send_cycle", ds_at, 6840);
        chk("post_abort_done_wait_cycle", dw_at, 9340);

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
